ppl_io_ctrl: RTL and testbench



---
 rtl/ppl_io_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ppl_io_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ppl_io_ctrl.sv
// ==========================================================================
// ppl_io_ctrl : memory-mapped key / seven-segment I/O controller for the
//               pipelined CPU (debounced keys, sticky events, blinking hex).
// Revision    : 1.0
// ==========================================================================
`default_nettype none

module ppl_io_ctrl #(
  parameter int          NUM_KEYS   = 10,
  parameter int          NUM_DISP   = 6,
  parameter int          DEB_CYCLES = 50000,
  parameter int          BLINK_DIV  = 25000000,
  parameter logic [31:0] IO_BASE    = 32'h0000_0080
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic                  we,
  output logic [31:0]           rdata,
  output logic                  sel,
  input  logic [NUM_KEYS-1:0]   keys,
  output logic [7*NUM_DISP-1:0] display
);

  localparam int c_DEB_W = $clog2(DEB_CYCLES);
  localparam int c_BLK_W = $clog2(BLINK_DIV);
  localparam logic [c_DEB_W-1:0] c_DEB_MAX = c_DEB_W'(DEB_CYCLES - 1);
  localparam logic [c_BLK_W-1:0] c_BLK_MAX = c_BLK_W'(BLINK_DIV - 1);
  localparam logic [7*NUM_DISP-1:0] c_SEG_OFF = '1;

  logic w_wr, w_wrEvent, w_wrValue, w_wrCtrl;
  logic w_unused;

  logic [NUM_KEYS-1:0]   r_sync1, r_sync2, w_stable, w_rise, w_clr, r_event;
  logic [4*NUM_DISP-1:0] r_dispValue;
  logic [NUM_DISP-1:0]   r_mask;
  logic                  r_blinkEn, r_phase;
  logic [c_BLK_W-1:0]    r_blinkCnt;

  assign sel       = (addr[31:4] == IO_BASE[31:4]);
  assign w_wr      = we & sel;
  assign w_wrEvent = w_wr & (addr[3:2] == 2'd1);
  assign w_wrValue = w_wr & (addr[3:2] == 2'd2);
  assign w_wrCtrl  = w_wr & (addr[3:2] == 2'd3);
  assign w_unused  = ^{addr[1:0], wdata};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= keys;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      logic [c_DEB_W-1:0] r_cnt;
      logic               r_stable;
      logic               w_accept;

      assign w_accept    = (r_sync2[k] != r_stable) && (r_cnt == c_DEB_MAX);
      assign w_rise[k]   = w_accept & r_sync2[k];
      assign w_stable[k] = r_stable;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (r_sync2[k] == r_stable) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_stable <= r_sync2[k];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  // A press landing on the same edge as its clear wins.
  assign w_clr = w_wrEvent ? wdata[NUM_KEYS-1:0] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_event <= '0;
    else        r_event <= (r_event & ~w_clr) | w_rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dispValue <= '0;
      r_mask      <= '1;
      r_blinkEn   <= 1'b0;
    end else begin
      if (w_wrValue) r_dispValue <= wdata[4*NUM_DISP-1:0];
      if (w_wrCtrl) begin
        r_mask    <= wdata[NUM_DISP-1:0];
        r_blinkEn <= wdata[8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
    end else if (w_wrCtrl && !wdata[8]) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
    end else if (r_blinkEn) begin
      if (r_blinkCnt == c_BLK_MAX) begin
        r_blinkCnt <= '0;
        r_phase    <= ~r_phase;
      end else begin
        r_blinkCnt <= r_blinkCnt + 1'b1;
      end
    end
  end

  function automatic logic [6:0] hexSeg(input logic [3:0] v);
    case (v)
      4'h0: hexSeg = 7'b1000000;
      4'h1: hexSeg = 7'b1111001;
      4'h2: hexSeg = 7'b0100100;
      4'h3: hexSeg = 7'b0110000;
      4'h4: hexSeg = 7'b0011001;
      4'h5: hexSeg = 7'b0010010;
      4'h6: hexSeg = 7'b0000010;
      4'h7: hexSeg = 7'b1111000;
      4'h8: hexSeg = 7'b0000000;
      4'h9: hexSeg = 7'b0010000;
      4'hA: hexSeg = 7'b0001000;
      4'hB: hexSeg = 7'b0000011;
      4'hC: hexSeg = 7'b1000110;
      4'hD: hexSeg = 7'b0100001;
      4'hE: hexSeg = 7'b0000110;
      default: hexSeg = 7'b0001110;
    endcase
  endfunction

  generate
    for (genvar i = 0; i < NUM_DISP; i++) begin : g_digit
      assign display[7*i +: 7] = (!r_mask[i] || (r_blinkEn && r_phase))
                                 ? c_SEG_OFF[7*i +: 7]
                                 : hexSeg(r_dispValue[4*i +: 4]);
    end
  endgenerate

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[3:2])
        2'd0: rdata[NUM_KEYS-1:0]   = w_stable;
        2'd1: rdata[NUM_KEYS-1:0]   = r_event;
        2'd2: rdata[4*NUM_DISP-1:0] = r_dispValue;
        default: begin
          rdata[NUM_DISP-1:0] = r_mask;
          rdata[8]            = r_blinkEn;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ppl_io_ctrl.sv
// ==========================================================================
// tb_ppl_io_ctrl : directed self-checking bench for ppl_io_ctrl
//                  (DEB_CYCLES=4, BLINK_DIV=8).
// Revision       : 1.0
// ==========================================================================
`default_nettype none

module tb_ppl_io_ctrl;

  localparam int NK = 10;
  localparam int ND = 6;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         SA = 7'b0001000, SB = 7'b0000011, SC = 7'b1000110,
                         SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110,
                         BL = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   addr, wdata, rdata;
  logic          we, sel;
  logic [NK-1:0] keys;
  logic [7*ND-1:0] display;

  int tests = 0;
  int fails = 0;

  ppl_io_ctrl #(
    .NUM_KEYS(NK), .NUM_DISP(ND), .DEB_CYCLES(4), .BLINK_DIV(8),
    .IO_BASE(32'h0000_0080)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .sel(sel), .keys(keys), .display(display)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic chkRd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    reset = 1'b0; addr = '0; wdata = '0; we = 1'b0; keys = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tick(2);

    // Reset state
    chkRd("rst_key_state", 32'h80, 32'h0);
    chk("sel_in_window", sel, 1'b1);
    chkRd("rst_key_event", 32'h84, 32'h0);
    chkRd("rst_disp_value", 32'h88, 32'h0);
    chkRd("rst_disp_ctrl", 32'h8C, 32'h3F);
    chk("rst_display", display, {6{S0}});
    chkRd("out_of_window_rdata", 32'h70, 32'h0);
    chk("out_of_window_sel", sel, 1'b0);
    chkRd("out_of_window_ctrl_alias", 32'h9C, 32'h0);

    // Display value and hex decode
    wr(32'h88, 32'h00FE_DCBA);
    chk("hex_af_display", display, {SF, SE, SD, SC, SB, SA});
    chkRd("disp_value_rb", 32'h88, 32'h00FE_DCBA);
    wr(32'h8A, 32'hFFFF_FFFF);
    chkRd("disp_value_trunc", 32'h88, 32'h00FF_FFFF);
    wr(32'h88, 32'h0054_3210);
    chk("hex_05_display", display, {S5, S4, S3, S2, S1, S0});

    // Debounce latency: keys[3] changes between edges, accepted on edge 6
    keys[3] = 1'b1;
    tick(5);
    chkRd("deb_state_edge5", 32'h80, 32'h0);
    chkRd("deb_event_edge5", 32'h84, 32'h0);
    tick(1);
    chkRd("deb_state_edge6", 32'h80, 32'h8);
    chkRd("deb_event_edge6", 32'h84, 32'h8);

    // 3-cycle glitch on keys[5] is rejected
    keys[5] = 1'b1;
    tick(3);
    keys[5] = 1'b0;
    tick(10);
    chkRd("glitch_state", 32'h80, 32'h8);
    chkRd("glitch_event", 32'h84, 32'h8);

    // Press of keys[0] lands on the same edge as a clear of bits 0 and 3
    keys[0] = 1'b1;
    tick(5);
    chkRd("race_state_before", 32'h80, 32'h8);
    wr(32'h84, 32'h9);
    chkRd("race_event", 32'h84, 32'h1);
    chkRd("race_state", 32'h80, 32'h9);

    // Release of a key sets no event
    wr(32'h84, 32'h1);
    chkRd("clear_event", 32'h84, 32'h0);
    keys[3] = 1'b0;
    tick(8);
    chkRd("release_state", 32'h80, 32'h1);
    chkRd("release_event", 32'h84, 32'h0);

    // Blink: mask digits 0 and 2, period 8 cycles per half
    wr(32'h8C, 32'h105);
    chkRd("ctrl_rb_blink", 32'h8C, 32'h105);
    chk("blink_ph0_start", display, {BL, BL, BL, S2, BL, S0});
    tick(7);
    chk("blink_ph0_end", display, {BL, BL, BL, S2, BL, S0});
    tick(1);
    chk("blink_ph1_start", display, {6{BL}});
    tick(7);
    chk("blink_ph1_end", display, {6{BL}});
    tick(1);
    chk("blink_ph0_again", display, {BL, BL, BL, S2, BL, S0});
    tick(8);
    chk("blink_ph1_again", display, {6{BL}});
    tick(3);
    wr(32'h8C, 32'h005);
    chkRd("ctrl_rb_steady", 32'h8C, 32'h5);
    chk("steady_now", display, {BL, BL, BL, S2, BL, S0});
    tick(10);
    chk("steady_later", display, {BL, BL, BL, S2, BL, S0});
    // Blink counter was cleared: full visible half-period again
    wr(32'h8C, 32'h105);
    tick(7);
    chk("reblink_ph0_end", display, {BL, BL, BL, S2, BL, S0});
    tick(1);
    chk("reblink_ph1_start", display, {6{BL}});

    // Asynchronous reset mid-blink and mid-debounce
    keys[7] = 1'b1;
    tick(6);
    chkRd("pre_reset_event", 32'h84, 32'h80);
    keys[7] = 1'b0;
    tick(3);
    #3;
    reset = 1'b0;
    keys  = '0;
    chkRd("arst_key_state", 32'h80, 32'h0);
    chkRd("arst_key_event", 32'h84, 32'h0);
    chkRd("arst_disp_value", 32'h88, 32'h0);
    chkRd("arst_disp_ctrl", 32'h8C, 32'h3F);
    chk("arst_display", display, {6{S0}});
    tick(2);
    reset = 1'b1;
    tick(12);
    chkRd("post_reset_event", 32'h84, 32'h0);
    chkRd("post_reset_state", 32'h80, 32'h0);
    chk("post_reset_display", display, {6{S0}});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
